m_dm_arbiter: RTL and testbench
===============================

# m_dm_arbiter

Data-memory access controller for the M stage. It shares the single-ported synchronous data RAM between the pipeline's load/store port and a DMA/debug word port. It sequences each access: issue, one-cycle read wait, and completion. It also generates byte enables and lane-replicated write data, extracts and extends sub-word load results, and stalls the pipeline while the memory is busy or held by the other requester.

## Interface
- `ADDR_W`, 12: word-address width of the RAM.
- `STARVE_MAX`, 4: CPU-won cycles that a pending DMA request tolerates before it is forced to win.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (one clock domain only).
- `cpu_req`  in  1  access request; held until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_op`  in  3  0 word, 1 half signed, 2 byte signed, 3 half unsigned, 4 byte unsigned (stores: 3→1, 4→2).
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, right-aligned.
- `cpu_ready`  out  1  access complete this cycle.
- `cpu_rdata`  out  32  extended load result, valid with `cpu_ready` on loads, else 0.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ready`.
- `cpu_err`  out  1  misaligned access (see Configuration).
- `dma_req`, `dma_we`  in  1 each  DMA request (held until `dma_gnt`) and write flag.
- `dma_addr`  in  32  byte address; bits [1:0] are ignored.
- `dma_wdata`  in  32  full-word store data.
- `dma_gnt`  out  1  DMA access issued this cycle.
- `dma_rvalid`  out  1  DMA read data valid.
- `dma_rdata`  out  32  raw word.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  4  byte write enables.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data; valid the cycle after the read is issued.

## Operation
- FSM states:
  - IDLE: arbitrate and issue.
  - CPU_RD: wait for the CPU read word.
  - DMA_RD: wait for the DMA read word.
- Arbitration happens in IDLE only.
  - The CPU wins by default.
  - The DMA wins when it is the only requester, or when `starve_cnt == STARVE_MAX`.
- `starve_cnt`:
  - Increments each cycle in which `dma_req` is high and the CPU is granted.
  - Clears when the DMA is granted or when `dma_req` is low.
  - Saturates at `STARVE_MAX`.
- Stores complete in the grant cycle and the FSM stays in IDLE.
- Byte enables:
  - word: 4'b1111.
  - half: 4'b0011, or 4'b1100 when `addr[1]=1`.
  - byte: `4'b0001 << addr[1:0]`.
- Write data is replicated across lanes:
  - byte: `{4{wdata[7:0]}}`.
  - half: `{2{wdata[15:0]}}`.
- Loads:
  - The grant cycle drives `mem_en=1, mem_we=0` and moves to `*_RD`.
  - `cpu_op` and `cpu_addr[1:0]` are latched at grant.
  - The next cycle performs extraction from `mem_rdata`, asserts ready, and returns to IDLE.
- Load extraction:
  - Half uses `addr[1]` to select [15:0] or [31:16].
  - Byte uses `addr[1:0]` to select a lane.
  - Signed ops sign-extend; unsigned ops zero-extend.
  - An `op` value of 5–7 returns 0.
- No new access is issued while in `*_RD`; `cpu_stall` stays high for any pending CPU request.
- A read in flight completes even if its requester drops `req`; the requester must not do so.
- Reset asserted mid-read: the read is aborted, no ready/rvalid is produced, and the FSM returns to IDLE.

## Timing
- Reset values:
  - state IDLE, `starve_cnt` 0, latched op/addr 0.
  - All outputs 0, except `mem_addr`, which is don't-care and is driven to 0.
- Write latency: 0 cycles; `cpu_ready`/`dma_gnt` go high in the request cycle when granted.
- Read latency: 1 cycle.
  - CPU: `cpu_ready` and `cpu_rdata` at T+1.
  - DMA: `dma_gnt` at T, `dma_rvalid` and `dma_rdata` at T+1.
- Back-to-back reads sustain one per 2 cycles; back-to-back writes sustain one per cycle.
- Grant, ready and `mem_*` outputs are combinational from state and requests. State, counter and latches are registered.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - A CPU half access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, is misaligned.
  - It is granted as a zero-cycle access: `cpu_ready=1`, `cpu_err=1`, `mem_en=0`, `cpu_rdata=0`, FSM stays in IDLE.
  - It counts as a CPU grant for `starve_cnt`.
- Undefined:
  - `cpu_err` is tied to 0.
  - Unused low address bits are ignored: word addresses are aligned down, halves use `addr[1]`.

## Structure
- `dm_pkg` holds:
  - `cpu_op` encoding constants (`DM_W`, `DM_H`, `DM_B`, `DM_HU`, `DM_BU`).
  - The FSM state enum.
  - Byte-enable and replication helper functions.
- Sub-module `dm_load_ext`: combinational extraction and extension of (word, addr[1:0], op) to a 32-bit result. It is instantiated once, on the CPU read path.

## Test plan
- lb at addr 0x13, `mem_rdata`=0x80FF_1234 → at T+1 `cpu_ready=1`, `cpu_rdata`=0xFFFF_FF80. Repeat with lbu → 0x0000_0080.
- sh at addr 0x12, wdata 0x0000_ABCD → same cycle `mem_we`=4'b1100, `mem_addr`=0x4, `mem_wdata`=0xABCD_ABCD, `cpu_ready=1`.
- CPU issues continuous sw and `dma_req` is held high, `STARVE_MAX`=4 → CPU granted cycles 0–3, `dma_gnt` in cycle 4, CPU stalled in cycle 4, CPU resumes in cycle 5.
- DMA lw at 0x40 alone, RAM word 0xDEAD_BEEF → `dma_gnt` at T, `dma_rvalid=1` and `dma_rdata`=0xDEAD_BEEF at T+1. A simultaneous CPU request stalls through T+1.
- CPU lh granted, reset asserted at T+1 before the clock edge → no `cpu_ready`, all outputs 0, first post-reset request granted from IDLE.
- With `DM_ALIGN_CHECK_EN`, lw at 0x6 → `cpu_ready=1`, `cpu_err=1`, `mem_en=0`. Without the macro → `mem_addr`=0x1, normal read.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the M-stage data-memory controller: op codes,
// FSM state encoding and store-lane helpers.
package dm_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_B  = 3'd2;
    localparam logic [2:0] DM_HU = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_DMA_RD = 2'd2
    } dm_state_e;

    function automatic logic dm_is_half(input logic [2:0] op);
        return (op == DM_H) || (op == DM_HU);
    endfunction

    function automatic logic dm_is_byte(input logic [2:0] op);
        return (op == DM_B) || (op == DM_BU);
    endfunction

    // Undefined op codes produce no byte enables so a bad store writes nothing.
    function automatic logic [3:0] dm_byte_en(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        if (op == DM_W)
            be = 4'b1111;
        else if (dm_is_half(op))
            be = a[1] ? 4'b1100 : 4'b0011;
        else if (dm_is_byte(op))
            be = 4'b0001 << a;
        return be;
    endfunction

    function automatic logic [31:0] dm_wdata_rep(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        if (dm_is_half(op))
            r = {2{wd[15:0]}};
        else if (dm_is_byte(op))
            r = {4{wd[7:0]}};
        return r;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Sub-word load extraction: selects the addressed half/byte of a RAM word
// and sign- or zero-extends it according to the load op.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = addr[1] ? word[31:16] : word[15:0];
        unique case (addr)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
    end

    always_comb begin
        result = 32'h0;
        case (op)
            DM_W:    result = word;
            DM_H:    result = {{16{half_v[15]}}, half_v};
            DM_HU:   result = {16'h0, half_v};
            DM_B:    result = {{24{byte_v[7]}}, byte_v};
            DM_BU:   result = {24'h0, byte_v};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/m_dm_arbiter.sv
// M-stage data-memory controller: shares one synchronous RAM between the CPU
// load/store port and a DMA word port. Optional macro DM_ALIGN_CHECK_EN
// enables misalignment detection on CPU accesses.
//
// state     | meaning
// ----------+--------------------------------------------
// ST_IDLE   | arbitrate; issue stores/reads, stores finish here
// ST_CPU_RD | RAM word for a CPU load arrives, extract and complete
// ST_DMA_RD | RAM word for a DMA read arrives, return it raw
module m_dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_op,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    dm_state_e   state;
    logic [CW-1:0] starve_cnt;
    logic [2:0]  lat_op;
    logic [1:0]  lat_a;

    logic        cpu_mis;
    logic        dma_win;
    logic        cpu_win;
    logic [31:0] ext_data;
    logic        unused_bits;

`ifdef DM_ALIGN_CHECK_EN
    assign cpu_mis = (dm_is_half(cpu_op) && cpu_addr[0]) ||
                     ((cpu_op == DM_W) && (cpu_addr[1:0] != 2'b00));
`else
    assign cpu_mis = 1'b0;
`endif

    assign dma_win     = dma_req && (!cpu_req || (starve_cnt == STARVE_LIM));
    assign cpu_win     = cpu_req && !dma_win;
    assign unused_bits = ^{cpu_addr[31:ADDR_W+2], dma_addr[31:ADDR_W+2], dma_addr[1:0]};

    dm_load_ext u_load_ext (
        .word   (mem_rdata),
        .addr   (lat_a),
        .op     (lat_op),
        .result (ext_data)
    );

    // Outputs are forced low while reset is held so a pending request cannot
    // reach the RAM or produce a grant during reset.
    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rdata  = 32'h0;
        cpu_err    = 1'b0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = 32'h0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (dma_win) begin
                        dma_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = dma_we ? 4'b1111 : 4'b0000;
                        mem_addr  = dma_addr[ADDR_W+1:2];
                        mem_wdata = dma_we ? dma_wdata : 32'h0;
                    end else if (cpu_win) begin
                        if (cpu_mis) begin
                            cpu_ready = 1'b1;
                            cpu_err   = 1'b1;
                        end else begin
                            mem_en   = 1'b1;
                            mem_addr = cpu_addr[ADDR_W+1:2];
                            if (cpu_we) begin
                                mem_we    = dm_byte_en(cpu_op, cpu_addr[1:0]);
                                mem_wdata = dm_wdata_rep(cpu_op, cpu_wdata);
                                cpu_ready = 1'b1;
                            end
                        end
                    end
                end
                ST_CPU_RD: begin
                    cpu_ready = 1'b1;
                    cpu_rdata = ext_data;
                end
                ST_DMA_RD: begin
                    dma_rvalid = 1'b1;
                    dma_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            lat_op     <= 3'd0;
            lat_a      <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dma_win) begin
                        starve_cnt <= '0;
                        if (!dma_we)
                            state <= ST_DMA_RD;
                    end else if (cpu_win) begin
                        if (!dma_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 1'b1;
                        if (!cpu_we && !cpu_mis) begin
                            state  <= ST_CPU_RD;
                            lat_op <= cpu_op;
                            lat_a  <= cpu_addr[1:0];
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ST_CPU_RD, ST_DMA_RD: begin
                    state <= ST_IDLE;
                    if (!dma_req)
                        starve_cnt <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_dm_arbiter.sv
// Self-checking bench for m_dm_arbiter with a behavioural synchronous RAM;
// load results are queued at issue and compared when the DUT completes.
module tb_m_dm_arbiter;
    import dm_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [2:0]        cpu_op;
    logic [31:0]       cpu_addr, cpu_wdata;
    logic              cpu_ready, cpu_stall, cpu_err;
    logic [31:0]       cpu_rdata;
    logic              dma_req, dma_we;
    logic [31:0]       dma_addr, dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [31:0]       dma_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    logic [31:0] ram [0:4095];
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    m_dm_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_op     (cpu_op),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_err    (cpu_err),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000)
                mem_rdata <= ram[mem_addr];
            else
                for (int b = 0; b < 4; b++)
                    if (mem_we[b])
                        ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_op    = DM_W;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = 32'h0;
        dma_wdata = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"},
                  {22'h0, cpu_ready, cpu_stall, cpu_err, dma_gnt, dma_rvalid, mem_en, mem_we}, 32'h0);
        check_val({tag, "_data"}, cpu_rdata | dma_rdata | mem_wdata | {20'h0, mem_addr}, 32'h0);
    endtask

    task automatic cpu_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] exp);
        int n;
        logic [31:0] e;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_op   = op;
        cpu_addr = addr;
        exp_q.push_back(exp);
        #2;
        check_val({tag, "_issue"}, {31'h0, mem_en}, 32'h1);
        n = 0;
        while (!cpu_ready && n < 6) begin
            @(negedge clk);
            #2;
            n++;
        end
        e = exp_q.pop_front();
        check_val({tag, "_lat"}, 32'(n), 32'd1);
        check_val(tag, cpu_rdata, e);
        @(negedge clk);
        idle_in();
    endtask

    task automatic cpu_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] exp_we,
                             input logic [31:0] exp_wd, input logic [31:0] exp_addr);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_op    = op;
        cpu_addr  = addr;
        cpu_wdata = wd;
        #2;
        check_val({tag, "_we"}, {28'h0, mem_we}, {28'h0, exp_we});
        check_val({tag, "_wdata"}, mem_wdata, exp_wd);
        check_val({tag, "_addr"}, {20'h0, mem_addr}, exp_addr);
        check_val({tag, "_ready"}, {30'h0, cpu_ready, mem_en}, 32'h3);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] e;
        idle_in();
        reset = 1'b0;
        ram[1]  <= 32'h1122_3344;
        ram[4]  <= 32'h80FF_1234;
        ram[16] <= 32'hDEAD_BEEF;
        cpu_req = 1'b1;
        #12;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        idle_in();
        reset = 1'b1;

        cpu_load("lb_13",  DM_B,  32'h13, 32'hFFFF_FF80);
        cpu_load("lbu_13", DM_BU, 32'h13, 32'h0000_0080);
        cpu_load("lh_12",  DM_H,  32'h12, 32'hFFFF_80FF);
        cpu_load("lhu_12", DM_HU, 32'h12, 32'h0000_80FF);
        cpu_load("lw_10",  DM_W,  32'h10, 32'h80FF_1234);
        cpu_load("lb_11",  DM_B,  32'h11, 32'h0000_0012);
        cpu_load("lbu_10", DM_BU, 32'h10, 32'h0000_0034);
        cpu_load("lhu_10", DM_HU, 32'h10, 32'h0000_1234);
        cpu_load("lop5",   3'd5,  32'h10, 32'h0000_0000);

        cpu_store("sh_12", DM_H, 32'h12, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h4);
        cpu_store("sb_13", DM_B, 32'h13, 32'h0000_005A, 4'b1000, 32'h5A5A_5A5A, 32'h4);
        cpu_store("sw_20", DM_W, 32'h20, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'h8);
        cpu_load("lw_after_st", DM_W, 32'h10, 32'h5ACD_1234);
        cpu_load("lw_20", DM_W, 32'h20, 32'h1234_5678);

        // DMA held against continuous CPU stores must win on the fifth cycle.
        @(negedge clk);
        idle_in();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_op    = DM_W;
            cpu_addr  = 32'h200 + 32'(4 * c);
            cpu_wdata = 32'(c);
            dma_req   = (c <= 4);
            dma_we    = 1'b1;
            dma_addr  = 32'h300;
            dma_wdata = 32'h77;
            exp_q.push_back({29'h0, (c != 4), (c == 4), (c == 4)});
            #2;
            e = exp_q.pop_front();
            check_val($sformatf("starve_c%0d", c), {29'h0, cpu_ready, dma_gnt, cpu_stall}, e);
        end
        @(negedge clk);
        idle_in();

        @(negedge clk);
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 32'h40;
        exp_q.push_back(32'hDEAD_BEEF);
        #2;
        check_val("dma_gnt", {31'h0, dma_gnt}, 32'h1);
        check_val("dma_issue", {27'h0, mem_en, mem_we}, 32'h10);
        check_val("dma_addr", {20'h0, mem_addr}, 32'h10);
        @(negedge clk);
        dma_req  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_op   = DM_W;
        cpu_addr = 32'h4;
        #2;
        e = exp_q.pop_front();
        check_val("dma_rvalid", {31'h0, dma_rvalid}, 32'h1);
        check_val("dma_rdata", dma_rdata, e);
        check_val("dma_rd_cpu", {29'h0, cpu_stall, cpu_ready, mem_en}, 32'h4);
        @(negedge clk);
        exp_q.push_back(32'h1122_3344);
        #2;
        check_val("cpu_after_dma_issue", {30'h0, cpu_stall, mem_en}, 32'h3);
        @(negedge clk);
        #2;
        e = exp_q.pop_front();
        check_val("cpu_after_dma_ready", {31'h0, cpu_ready}, 32'h1);
        check_val("cpu_after_dma_rdata", cpu_rdata, e);
        @(negedge clk);
        idle_in();

        @(negedge clk);
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 32'h4B;
        dma_wdata = 32'hCAFE_F00D;
        #2;
        check_val("dma_wr_we", {27'h0, dma_gnt, mem_we}, 32'h1F);
        check_val("dma_wr_wdata", mem_wdata, 32'hCAFE_F00D);
        check_val("dma_wr_addr", {20'h0, mem_addr}, 32'h12);
        @(negedge clk);
        idle_in();
        #2;
        check_val("dma_wr_no_rvalid", {31'h0, dma_rvalid}, 32'h0);
        cpu_load("lw_dma_wr", DM_W, 32'h48, 32'hCAFE_F00D);

`ifdef DM_ALIGN_CHECK_EN
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_op   = DM_W;
        cpu_addr = 32'h6;
        #2;
        check_val("mis_lw", {29'h0, cpu_ready, cpu_err, mem_en}, 32'h6);
        check_val("mis_lw_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        cpu_we    = 1'b1;
        cpu_op    = DM_H;
        cpu_addr  = 32'h13;
        cpu_wdata = 32'h1111;
        #2;
        check_val("mis_sh", {25'h0, cpu_ready, cpu_err, mem_en, mem_we}, 32'h60);
        @(negedge clk);
        idle_in();
        #2;
        check_val("mis_no_rd", {31'h0, cpu_ready}, 32'h0);
`else
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_op   = DM_W;
        cpu_addr = 32'h6;
        exp_q.push_back(32'h1122_3344);
        #2;
        check_val("unal_lw_issue", {29'h0, cpu_err, cpu_ready, mem_en}, 32'h1);
        check_val("unal_lw_addr", {20'h0, mem_addr}, 32'h1);
        @(negedge clk);
        #2;
        e = exp_q.pop_front();
        check_val("unal_lw_ready", {30'h0, cpu_ready, cpu_err}, 32'h2);
        check_val("unal_lw_rdata", cpu_rdata, e);
        @(negedge clk);
        idle_in();
`endif

        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_op   = DM_H;
        cpu_addr = 32'h12;
        #2;
        check_val("rst_rd_issue", {31'h0, mem_en}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_all_zero("rst_mid_rd");
        @(negedge clk);
        #2;
        check_all_zero("rst_held");
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(32'h0000_5ACD);
        #2;
        check_val("post_rst_issue", {30'h0, cpu_ready, mem_en}, 32'h1);
        @(negedge clk);
        #2;
        e = exp_q.pop_front();
        check_val("post_rst_ready", {31'h0, cpu_ready}, 32'h1);
        check_val("post_rst_rdata", cpu_rdata, e);
        @(negedge clk);
        idle_in();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
